// File: rtl/merge_query_buffer_if.sv
// -----------------------------------------------------------------------------
// merge_query_buffer_if
//   Bundles the input item stream, the consumer request/response and the queue
//   status of merge_query_buffer.
//   master : drives valid_in, item_in, item_counter_in, output_ready
//   slave  : drives valid_out, item_out, item_counter, queue_full_signal,
//            queue_emtpy_signal, dbg_item_size
// -----------------------------------------------------------------------------
interface merge_query_buffer_if #(
    parameter int ITEM_LENGTH       = 48,
    parameter int ITEM_COUNTER_SIZE = 12
);
    logic                         valid_in;
    logic [ITEM_LENGTH-1:0]       item_in;
    logic [ITEM_COUNTER_SIZE-2:0] item_counter_in;
    logic                         output_ready;
    logic                         valid_out;
    logic [ITEM_LENGTH-1:0]       item_out;
    logic [ITEM_COUNTER_SIZE-1:0] item_counter;
    logic                         queue_full_signal;
    logic                         queue_emtpy_signal;
    logic [5:0]                   dbg_item_size;

    modport master (
        output valid_in, item_in, item_counter_in, output_ready,
        input  valid_out, item_out, item_counter,
        input  queue_full_signal, queue_emtpy_signal, dbg_item_size
    );

    modport slave (
        input  valid_in, item_in, item_counter_in, output_ready,
        output valid_out, item_out, item_counter,
        output queue_full_signal, queue_emtpy_signal, dbg_item_size
    );
endinterface

// File: rtl/merge_query_buffer.sv
// -----------------------------------------------------------------------------
// merge_query_buffer
//   Merging FIFO of (item, count) pairs. An incoming item that matches a queued
//   entry adds its count (saturating) to that entry; otherwise it is appended at
//   the tail. Entries are popped oldest-first into registered outputs.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : merge_query_buffer_if.slave (item input, consumer request,
//           popped entry output, full/empty/occupancy status)
// -----------------------------------------------------------------------------
module merge_query_buffer #(
    parameter int ITEM_LENGTH       = 48,
    parameter int ITEM_COUNTER_SIZE = 12,
    parameter int QUEUE_LEN         = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    merge_query_buffer_if.slave  bus
);
    localparam int CW = ITEM_COUNTER_SIZE;

    typedef logic [ITEM_LENGTH-1:0] key_t;
    typedef logic [CW-1:0]          cnt_t;

    key_t       key_q [QUEUE_LEN];
    key_t       key_d [QUEUE_LEN];
    cnt_t       cnt_q [QUEUE_LEN];
    cnt_t       cnt_d [QUEUE_LEN];
    logic [5:0] size_q, size_d;
    logic       valid_out_q, valid_out_d;
    key_t       item_out_q, item_out_d;
    cnt_t       item_cnt_q, item_cnt_d;

    logic       pop, bypass, head_hit, hit;
    logic [5:0] size_base;

    function automatic cnt_t sat_add(input cnt_t a, input logic [CW-2:0] b);
        logic [CW:0] sum;
        sum = {1'b0, a} + {2'b00, b};
        return sum[CW] ? '1 : sum[CW-1:0];
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        pop       = bus.output_ready && (size_q != '0);
        bypass    = bus.output_ready && (size_q == '0) && bus.valid_in;
        head_hit  = pop && bus.valid_in && (key_q[0] == bus.item_in);
        size_base = size_q - {5'd0, pop};
        size_d    = size_base;
        hit       = 1'b0;
        key_d     = key_q;
        cnt_d     = cnt_q;

        // NOTE: blocking assignments here let the match and append below see
        // the post-pop (shifted) contents within the same evaluation.
        if (pop) begin
            for (int i = 0; i < QUEUE_LEN - 1; i++) begin
                key_d[i] = key_q[i+1];
                cnt_d[i] = cnt_q[i+1];
            end
            key_d[QUEUE_LEN-1] = '0;
            cnt_d[QUEUE_LEN-1] = '0;
        end

        // Keys in the queue are distinct, so at most one entry can match; a
        // hit on the departing head is folded into the output instead.
        if (bus.valid_in && !bypass && !head_hit) begin
            for (int i = 0; i < QUEUE_LEN; i++) begin
                if (!hit && (i < int'(size_base)) && (key_d[i] == bus.item_in)) begin
                    hit      = 1'b1;
                    cnt_d[i] = sat_add(cnt_d[i], bus.item_counter_in);
                end
            end
            // A miss with no free slot (full and no pop) is dropped.
            if (!hit && (size_base != 6'(QUEUE_LEN))) begin
                for (int i = 0; i < QUEUE_LEN; i++) begin
                    if (i == int'(size_base)) begin
                        key_d[i] = bus.item_in;
                        cnt_d[i] = {1'b0, bus.item_counter_in};
                    end
                end
                size_d = size_base + 6'd1;
            end
        end

        valid_out_d = pop || bypass;
        item_out_d  = item_out_q;
        item_cnt_d  = item_cnt_q;
        if (pop) begin
            item_out_d = key_q[0];
            item_cnt_d = head_hit ? sat_add(cnt_q[0], bus.item_counter_in) : cnt_q[0];
        end else if (bypass) begin
            item_out_d = bus.item_in;
            item_cnt_d = {1'b0, bus.item_counter_in};
        end
    end

    // NOTE: the entry storage is reset too, so a cleared queue never carries
    // stale keys that a later occupancy bug could expose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_LEN; i++) begin
                key_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            size_q      <= '0;
            valid_out_q <= 1'b0;
            item_out_q  <= '0;
            item_cnt_q  <= '0;
        end else begin
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            valid_out_q <= valid_out_d;
            item_out_q  <= item_out_d;
            item_cnt_q  <= item_cnt_d;
        end
    end

    assign bus.valid_out          = valid_out_q;
    assign bus.item_out           = item_out_q;
    assign bus.item_counter       = item_cnt_q;
    assign bus.queue_full_signal  = (size_q == 6'(QUEUE_LEN));
    assign bus.queue_emtpy_signal = (size_q == '0);
    assign bus.dbg_item_size      = size_q;
endmodule

// File: tb/tb_merge_query_buffer.sv
// -----------------------------------------------------------------------------
// tb_merge_query_buffer
//   Self-checking bench for merge_query_buffer: a fixed vector table, directed
//   sequences for fill/drain, merge sums, bypass, drop and saturation, then
//   random traffic against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_merge_query_buffer;
    localparam int IL = 48;
    localparam int CS = 12;
    localparam int QL = 30;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    merge_query_buffer_if #(.ITEM_LENGTH(IL), .ITEM_COUNTER_SIZE(CS)) bus ();

    merge_query_buffer #(
        .ITEM_LENGTH(IL), .ITEM_COUNTER_SIZE(CS), .QUEUE_LEN(QL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [IL-1:0] key;
        logic [CS-1:0] cnt;
    } entry_t;

    entry_t        mq[$];
    logic          m_valid;
    logic [IL-1:0] m_item;
    logic [CS-1:0] m_cnt;

    function automatic logic [CS-1:0] sat(input logic [CS-1:0] a, input logic [CS-2:0] b);
        int s;
        s = int'(a) + int'(b);
        return (s > 4095) ? 12'hFFF : 12'(s);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_item  = '0;
        m_cnt   = '0;
    endtask

    task automatic model_step(input logic vin, input logic [IL-1:0] key,
                              input logic [CS-2:0] c, input logic rdy);
        entry_t head;
        bit     taken;
        int     idx;
        taken = 0;
        if (rdy && mq.size() > 0) begin
            head    = mq.pop_front();
            m_valid = 1'b1;
            m_item  = head.key;
            m_cnt   = head.cnt;
            if (vin && key == head.key) begin
                m_cnt = sat(m_cnt, c);
                taken = 1;
            end
        end else if (rdy && vin) begin
            m_valid = 1'b1;
            m_item  = key;
            m_cnt   = {1'b0, c};
            taken   = 1;
        end else begin
            m_valid = 1'b0;
        end
        if (vin && !taken) begin
            idx = -1;
            foreach (mq[i]) if (idx < 0 && mq[i].key == key) idx = i;
            if (idx >= 0) mq[idx].cnt = sat(mq[idx].cnt, c);
            else if (mq.size() < QL) mq.push_back('{key, {1'b0, c}});
        end
    endtask

    task automatic compare_model();
        check("valid_out", 64'(bus.valid_out), 64'(m_valid));
        check("item_out", 64'(bus.item_out), 64'(m_item));
        check("item_counter", 64'(bus.item_counter), 64'(m_cnt));
        check("size", 64'(bus.dbg_item_size), 64'(mq.size()));
        check("full", 64'(bus.queue_full_signal), 64'(mq.size() == QL));
        check("empty", 64'(bus.queue_emtpy_signal), 64'(mq.size() == 0));
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic vin, input logic [IL-1:0] key,
                        input logic [CS-2:0] c, input logic rdy);
        bus.valid_in        = vin;
        bus.item_in         = key;
        bus.item_counter_in = c;
        bus.output_ready    = rdy;
        model_step(vin, key, c, rdy);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_size"}, 64'(bus.dbg_item_size), 64'd0);
        check({tag, "_empty"}, 64'(bus.queue_emtpy_signal), 64'd1);
        check({tag, "_full"}, 64'(bus.queue_full_signal), 64'd0);
        check({tag, "_valid"}, 64'(bus.valid_out), 64'd0);
        check({tag, "_item"}, 64'(bus.item_out), 64'd0);
        check({tag, "_cnt"}, 64'(bus.item_counter), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          vin;
        logic [IL-1:0] key;
        logic [CS-2:0] cnt;
        logic          rdy;
        logic [5:0]    size;
        logic          vout;
        logic [IL-1:0] item;
        logic [CS-1:0] icnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int s1, s2, c;

        vecs[0] = '{1'b1, 48'd1, 11'd1, 1'b0, 6'd1, 1'b0, 48'd0, 12'd0};
        vecs[1] = '{1'b1, 48'd1, 11'd1, 1'b0, 6'd1, 1'b0, 48'd0, 12'd0};
        vecs[2] = '{1'b1, 48'd2, 11'd5, 1'b0, 6'd2, 1'b0, 48'd0, 12'd0};
        vecs[3] = '{1'b1, 48'd2, 11'd3, 1'b1, 6'd1, 1'b1, 48'd1, 12'd2};
        vecs[4] = '{1'b1, 48'd2, 11'd4, 1'b1, 6'd0, 1'b1, 48'd2, 12'd12};
        vecs[5] = '{1'b1, 48'd9, 11'd6, 1'b1, 6'd0, 1'b1, 48'd9, 12'd6};
        vecs[6] = '{1'b0, 48'd0, 11'd0, 1'b1, 6'd0, 1'b0, 48'd9, 12'd6};
        vecs[7] = '{1'b1, 48'd3, 11'd2, 1'b0, 6'd1, 1'b0, 48'd9, 12'd6};
        vecs[8] = '{1'b1, 48'd4, 11'd1, 1'b1, 6'd1, 1'b1, 48'd3, 12'd2};
        vecs[9] = '{1'b0, 48'd0, 11'd0, 1'b1, 6'd0, 1'b1, 48'd4, 12'd1};

        bus.valid_in        = 1'b0;
        bus.item_in         = '0;
        bus.item_counter_in = '0;
        bus.output_ready    = 1'b0;
        rst_n               = 1'b1;
        model_reset();

        // Reset before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: merge, post-pop match, head hit, bypass, hold, pop+append.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].vin, vecs[i].key, vecs[i].cnt, vecs[i].rdy);
            check($sformatf("vec%0d_size", i), 64'(bus.dbg_item_size), 64'(vecs[i].size));
            check($sformatf("vec%0d_valid", i), 64'(bus.valid_out), 64'(vecs[i].vout));
            check($sformatf("vec%0d_item", i), 64'(bus.item_out), 64'(vecs[i].item));
            check($sformatf("vec%0d_cnt", i), 64'(bus.item_counter), 64'(vecs[i].icnt));
        end

        // Asynchronous reset mid-run: visible before the next clock edge.
        step(1'b1, 48'd1, 11'd1, 1'b0);
        step(1'b1, 48'd2, 11'd1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_rst");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill keys 1..30, then drop a new key and saturate key 5.
        for (int k = 1; k <= QL; k++) begin
            step(1'b1, 48'(k), 11'd1, 1'b0);
            check("fill_size", 64'(bus.dbg_item_size), 64'(k));
            check("fill_full", 64'(bus.queue_full_signal), 64'(k == QL));
        end
        step(1'b1, 48'd99, 11'd7, 1'b0);
        check("drop_size", 64'(bus.dbg_item_size), 64'd30);
        for (int j = 0; j < 3; j++) step(1'b1, 48'd5, 11'd2047, 1'b0);

        // Drain in order.
        for (int k = 1; k <= QL; k++) begin
            step(1'b0, '0, '0, 1'b1);
            check("drain_valid", 64'(bus.valid_out), 64'd1);
            check("drain_key", 64'(bus.item_out), 64'(k));
            check("drain_sum", 64'(bus.item_out) + 64'(bus.dbg_item_size), 64'd30);
            if (k == 5) check("sat_cnt", 64'(bus.item_counter), 64'd4095);
        end
        step(1'b0, '0, '0, 1'b1);
        check("drained_valid", 64'(bus.valid_out), 64'd0);
        check("drained_empty", 64'(bus.queue_emtpy_signal), 64'd1);

        // Alternating keys 1/2 with random counts.
        s1 = 0;
        s2 = 0;
        for (int j = 0; j < 20; j++) begin
            c = int'($urandom_range(1, 16));
            if (j % 2 == 0) s1 += c; else s2 += c;
            step(1'b1, 48'((j % 2) + 1), 11'(c), 1'b0);
        end
        check("alt_size", 64'(bus.dbg_item_size), 64'd2);
        step(1'b0, '0, '0, 1'b1);
        check("alt_key1", 64'(bus.item_out), 64'd1);
        check("alt_sum1", 64'(bus.item_counter), 64'(s1));
        step(1'b0, '0, '0, 1'b1);
        check("alt_key2", 64'(bus.item_out), 64'd2);
        check("alt_sum2", 64'(bus.item_counter), 64'(s2));

        // Bypass on an empty queue.
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 48'(k), 11'(k + 1), 1'b1);
            check("byp_valid", 64'(bus.valid_out), 64'd1);
            check("byp_item", 64'(bus.item_out), 64'(k));
            check("byp_cnt", 64'(bus.item_counter), 64'(k + 1));
            check("byp_size", 64'(bus.dbg_item_size), 64'd0);
        end

        // Random traffic: wide key range with rare pops reaches full; narrow
        // key range with frequent pops stresses merging and head hits.
        for (int n = 0; n < 1500; n++)
            step(1'($urandom_range(0, 3) != 0), 48'($urandom_range(1, 40)),
                 11'($urandom_range(0, 2047)), 1'($urandom_range(0, 4) == 0));
        for (int n = 0; n < 1500; n++)
            step(1'($urandom_range(0, 1)), 48'($urandom_range(1, 6)),
                 11'($urandom_range(0, 1500)), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
